// File: rtl/lcd_pkg.sv
// Shared constants, command classes and address helpers for the LCD bus responder.
package lcd_pkg;

    localparam logic [6:0]  LINE2_BASE = 7'h40;
    localparam logic [6:0]  LINE1_LAST = 7'h27;
    localparam logic [6:0]  LINE2_LAST = 7'h67;
    localparam int unsigned LINE_LEN   = 40;
    localparam int unsigned DDRAM_SIZE = 2 * LINE_LEN;
    localparam logic [7:0]  BLANK      = 8'h20;

    // {DL,N,F} bit positions within func_set
    localparam int unsigned FS_DL = 2;
    localparam int unsigned FS_N  = 1;
    localparam int unsigned FS_F  = 0;
    localparam logic [2:0]  FUNC_SET_RESET = 3'(1 << FS_DL);

    typedef enum logic [3:0] {
        CMD_NONE,
        CMD_CLEAR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISP,
        CMD_SHIFT,
        CMD_FUNC,
        CMD_CGRAM,
        CMD_DDRAM
    } cmd_e;

    // Commands are classified by the highest set bit of the instruction byte.
    function automatic cmd_e decode_cmd(input logic [7:0] db);
        casez (db)
            8'b1???_????: return CMD_DDRAM;
            8'b01??_????: return CMD_CGRAM;
            8'b001?_????: return CMD_FUNC;
            8'b0001_????: return CMD_SHIFT;
            8'b0000_1???: return CMD_DISP;
            8'b0000_01??: return CMD_ENTRY;
            8'b0000_001?: return CMD_HOME;
            8'b0000_0001: return CMD_CLEAR;
            default:      return CMD_NONE;
        endcase
    endfunction

    function automatic logic [6:0] ddram_index(input logic [6:0] a);
        return a[6] ? 7'(LINE_LEN) + {1'b0, a[5:0]} : {1'b0, a[5:0]};
    endfunction

    function automatic logic ac_valid(input logic [6:0] a);
        return (a <= LINE1_LAST) || (a >= LINE2_BASE && a <= LINE2_LAST);
    endfunction

    function automatic logic [5:0] shift_step(input logic [5:0] s, input logic up);
        if (up)
            return (s == 6'(LINE_LEN - 1)) ? 6'd0 : s + 6'd1;
        else
            return (s == 6'd0) ? 6'(LINE_LEN - 1) : s - 6'd1;
    endfunction

endpackage

// File: rtl/lcd_ac_step.sv
// Address-counter step with the two-line wrap rules (27h<->40h, 67h<->00h).
module lcd_ac_step
    import lcd_pkg::*;
(
    input  logic [6:0] ac,
    input  logic       dir,
    output logic [6:0] ac_next
);

    always_comb begin
        ac_next = ac + 7'd1;
        if (dir) begin
            if (ac == LINE1_LAST)
                ac_next = LINE2_BASE;
            else if (ac == LINE2_LAST)
                ac_next = '0;
        end else begin
            ac_next = ac - 7'd1;
            if (ac == 7'h00)
                ac_next = LINE2_LAST;
            else if (ac == LINE2_BASE)
                ac_next = LINE1_LAST;
        end
    end

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style responder: decodes bus cycles, holds DDRAM, AC, mode flags and busy flag.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int unsigned CLEAR_BUSY_CYC = 0,
    parameter int unsigned CMD_BUSY_CYC   = 0
) (
    input  logic       clock500Hz,
    input  logic       reset,
    input  logic       cs,
    input  logic       RS,
    input  logic       RW,
    input  logic [7:0] DB_in,
    output logic [7:0] DB_out,
    output logic       DB_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic [2:0] func_set,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    input  logic [4:0] mon_addr,
    output logic [7:0] mon_char,
    output logic       proto_err
);

    localparam logic [15:0] CLEAR_N = 16'(CLEAR_BUSY_CYC);
    localparam logic [15:0] CMD_N   = 16'(CMD_BUSY_CYC);

    logic [7:0]  ddram [DDRAM_SIZE];
    logic        inc_dir;
    logic        shift_en;
    logic        cg_mode;
    logic [5:0]  shift;
    logic [15:0] busy_cnt;
    logic        step_dir;
    logic [6:0]  ac_next;
    cmd_e        cmd;

    assign busy     = (busy_cnt != '0);
    assign cmd      = decode_cmd(DB_in);
    // Data cycles step along I/D; cursor-shift commands step along DB[2].
    assign step_dir = RS ? inc_dir : DB_in[2];

    lcd_ac_step u_ac_step (
        .ac      (ac),
        .dir     (step_dir),
        .ac_next (ac_next)
    );

    always_ff @(posedge clock500Hz or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DDRAM_SIZE; i++)
                ddram[i] <= BLANK;
            ac        <= '0;
            inc_dir   <= 1'b1;
            shift_en  <= 1'b0;
            cg_mode   <= 1'b0;
            shift     <= '0;
            func_set  <= FUNC_SET_RESET;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            busy_cnt  <= '0;
            DB_out    <= '0;
            DB_oe     <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            DB_oe     <= 1'b0;
            proto_err <= 1'b0;
            if (busy)
                busy_cnt <= busy_cnt - 16'd1;
            if (cs) begin
                if (RW) begin
                    DB_oe <= 1'b1;
                    if (!RS) begin
                        DB_out <= {busy, ac};
                    end else begin
                        DB_out <= ddram[ddram_index(ac)];
                        ac     <= ac_next;
                    end
                end else if (busy) begin
                    proto_err <= 1'b1;
                end else if (RS) begin
                    busy_cnt <= CMD_N;
                    if (!cg_mode) begin
                        ddram[ddram_index(ac)] <= DB_in;
                        ac <= ac_next;
                        if (shift_en)
                            shift <= shift_step(shift, inc_dir);
                    end
                end else begin
                    busy_cnt <= CMD_N;
                    unique case (cmd)
                        CMD_CLEAR: begin
                            for (int unsigned i = 0; i < DDRAM_SIZE; i++)
                                ddram[i] <= BLANK;
                            ac       <= '0;
                            inc_dir  <= 1'b1;
                            shift    <= '0;
                            busy_cnt <= CLEAR_N;
                        end
                        CMD_HOME: begin
                            ac       <= '0;
                            shift    <= '0;
                            busy_cnt <= CLEAR_N;
                        end
                        CMD_ENTRY: begin
                            inc_dir  <= DB_in[1];
                            shift_en <= DB_in[0];
                        end
                        CMD_DISP: begin
                            disp_on   <= DB_in[2];
                            cursor_on <= DB_in[1];
                            blink_on  <= DB_in[0];
                        end
                        CMD_SHIFT: begin
                            if (DB_in[3])
                                shift <= shift_step(shift, !DB_in[2]);
                            else
                                ac <= ac_next;
                        end
                        CMD_FUNC:  func_set <= DB_in[4:2];
                        CMD_CGRAM: cg_mode  <= 1'b1;
                        CMD_DDRAM: begin
                            // An out-of-range address is rejected and does not start a busy period.
                            if (ac_valid(DB_in[6:0])) begin
                                ac      <= DB_in[6:0];
                                cg_mode <= 1'b0;
                            end else begin
                                proto_err <= 1'b1;
                                busy_cnt  <= '0;
                            end
                        end
                        default: busy_cnt <= '0;
                    endcase
                end
            end
        end
    end

    logic [6:0] col_sum;
    logic [5:0] col;
    logic [6:0] mon_idx;

    always_comb begin
        col_sum  = {3'b000, mon_addr[3:0]} + {1'b0, shift};
        col      = (col_sum >= 7'(LINE_LEN)) ? 6'(col_sum - 7'(LINE_LEN)) : col_sum[5:0];
        mon_idx  = mon_addr[4] ? 7'(LINE_LEN) + {1'b0, col} : {1'b0, col};
        mon_char = ddram[mon_idx];
    end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: one instance without busy timing, one with CLEAR_BUSY_CYC=2.
module tb_lcd_bus_responder;

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] db;
        logic [6:0] ac;
        logic       oe;
        logic [7:0] out;
        logic       err;
    } vec_t;

    logic       clock500Hz = 1'b0;
    logic       reset;
    logic       cs_a, cs_b, RS, RW;
    logic [7:0] DB_in;
    logic [4:0] mon_addr;

    logic [7:0] a_out, b_out, a_mon, b_mon;
    logic       a_oe, b_oe, a_busy, b_busy, a_disp, b_disp, a_cur, b_cur, a_blink, b_blink;
    logic       a_err, b_err;
    logic [6:0] a_ac, b_ac;
    logic [2:0] a_fs, b_fs;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clock500Hz = ~clock500Hz;

    lcd_bus_responder dut_a (
        .clock500Hz(clock500Hz), .reset(reset), .cs(cs_a), .RS(RS), .RW(RW), .DB_in(DB_in),
        .DB_out(a_out), .DB_oe(a_oe), .busy(a_busy), .ac(a_ac), .func_set(a_fs),
        .disp_on(a_disp), .cursor_on(a_cur), .blink_on(a_blink),
        .mon_addr(mon_addr), .mon_char(a_mon), .proto_err(a_err)
    );

    lcd_bus_responder #(.CLEAR_BUSY_CYC(2), .CMD_BUSY_CYC(0)) dut_b (
        .clock500Hz(clock500Hz), .reset(reset), .cs(cs_b), .RS(RS), .RW(RW), .DB_in(DB_in),
        .DB_out(b_out), .DB_oe(b_oe), .busy(b_busy), .ac(b_ac), .func_set(b_fs),
        .disp_on(b_disp), .cursor_on(b_cur), .blink_on(b_blink),
        .mon_addr(mon_addr), .mon_char(b_mon), .proto_err(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One bus cycle; inputs change 1 time unit after the edge, outputs are stable on return.
    task automatic cyc(input logic sel_b, input logic en, input logic rs, input logic rw,
                       input logic [7:0] db);
        cs_a  = en & ~sel_b;
        cs_b  = en & sel_b;
        RS    = rs;
        RW    = rw;
        DB_in = db;
        @(posedge clock500Hz);
        #1;
        cs_a = 1'b0;
        cs_b = 1'b0;
    endtask

    task automatic mon_a(input logic [4:0] addr, output logic [7:0] ch);
        mon_addr = addr;
        #1;
        ch = a_mon;
    endtask

    task automatic add(input logic rs, input logic rw, input logic [7:0] db, input logic [6:0] ac,
                       input logic oe, input logic [7:0] out, input logic err);
        vec_t v;
        v.rs = rs; v.rw = rw; v.db = db; v.ac = ac; v.oe = oe; v.out = out; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            cyc(1'b0, 1'b1, vecs[i].rs, vecs[i].rw, vecs[i].db);
            chk($sformatf("row%0d_ac", i), a_ac, vecs[i].ac);
            chk($sformatf("row%0d_oe", i), a_oe, vecs[i].oe);
            chk($sformatf("row%0d_err", i), a_err, vecs[i].err);
            if (vecs[i].oe)
                chk($sformatf("row%0d_out", i), a_out, vecs[i].out);
        end
    endtask

    initial begin
        logic [7:0] ch;
        int         bad;

        reset = 1'b1; cs_a = 1'b0; cs_b = 1'b0; RS = 1'b0; RW = 1'b0; DB_in = '0; mon_addr = '0;

        // Init sequence
        for (int i = 0; i < 4; i++) add(0, 0, 8'h38, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h01, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h0C, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h06, 7'h00, 0, 8'h00, 0);
        // Line 1 fill, jump to line 2
        for (int i = 0; i < 16; i++) add(1, 0, 8'(8'h41 + i), 7'(i + 1), 0, 8'h00, 0);
        add(0, 0, 8'hC0, 7'h40, 0, 8'h00, 0);
        add(1, 0, 8'h61, 7'h41, 0, 8'h00, 0);
        // Wrap boundaries and invalid address
        add(0, 0, 8'hA7, 7'h27, 0, 8'h00, 0);
        add(1, 0, 8'h5A, 7'h40, 0, 8'h00, 0);
        add(0, 0, 8'hE7, 7'h67, 0, 8'h00, 0);
        add(1, 0, 8'h5B, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h04, 7'h00, 0, 8'h00, 0);
        add(1, 0, 8'h41, 7'h67, 0, 8'h00, 0);
        add(0, 0, 8'hC0, 7'h40, 0, 8'h00, 0);
        add(1, 1, 8'h00, 7'h27, 1, 8'h61, 0);
        add(0, 0, 8'hA8, 7'h27, 0, 8'h00, 1);
        // Reads at ac=0
        add(0, 0, 8'h80, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h06, 7'h00, 0, 8'h00, 0);
        add(0, 1, 8'h00, 7'h00, 1, 8'h00, 0);
        add(1, 1, 8'h00, 7'h01, 1, 8'h41, 0);

        #2;
        chk("rst_ac", a_ac, 7'h00);
        chk("rst_fs", a_fs, 3'b100);
        chk("rst_oe", a_oe, 1'b0);
        chk("rst_out", a_out, 8'h00);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_err", a_err, 1'b0);
        chk("rst_disp", a_disp, 1'b0);
        #10;
        reset = 1'b0;
        @(posedge clock500Hz);
        #1;

        run_rows(0, 7);
        chk("init_fs", a_fs, 3'b110);
        chk("init_disp", a_disp, 1'b1);
        chk("init_cursor", a_cur, 1'b0);
        chk("init_blink", a_blink, 1'b0);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            mon_a(5'(i), ch);
            if (ch !== 8'h20) bad++;
        end
        chk("init_mon_blank_count", 32'(bad), 32'd0);

        run_rows(7, vecs.size());
        mon_a(5'd0, ch);  chk("mon0", ch, 8'h41);
        mon_a(5'd15, ch); chk("mon15", ch, 8'h50);
        mon_a(5'd16, ch); chk("mon16", ch, 8'h61);
        mon_a(5'd31, ch); chk("mon31", ch, 8'h20);

        // Bus ignored while cs=0
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h99);
        chk("cs0_ac", a_ac, 7'h01);
        mon_a(5'd0, ch); chk("cs0_mon0", ch, 8'h41);
        chk("cs0_disp", a_disp, 1'b1);

        // Display and cursor shifts
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h18);
        mon_a(5'd0, ch); chk("shl_mon0", ch, 8'h42);
        mon_a(5'd15, ch); chk("shl_mon15", ch, 8'h20);
        chk("shl_ac", a_ac, 7'h01);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h1C);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h1C);
        mon_a(5'd0, ch); chk("shr_wrap_mon0", ch, 8'h5A);
        mon_a(5'd16, ch); chk("shr_wrap_mon16", ch, 8'h5B);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h14);
        chk("cur_right_ac", a_ac, 7'h02);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
        chk("cur_left_ac", a_ac, 7'h01);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
        chk("home_ac", a_ac, 7'h00);
        mon_a(5'd0, ch); chk("home_mon0", ch, 8'h41);

        // Reset asserted in the middle of a write cycle
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
        cs_a = 1'b1; RS = 1'b1; RW = 1'b0; DB_in = 8'h78;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_ac", a_ac, 7'h00);
        chk("midrst_fs", a_fs, 3'b100);
        chk("midrst_disp", a_disp, 1'b0);
        mon_a(5'd0, ch); chk("midrst_mon0", ch, 8'h20);
        cs_a = 1'b0;
        #8;
        reset = 1'b0;
        @(posedge clock500Hz);
        #1;
        chk("midrst_hold_ac", a_ac, 7'h00);
        chk("midrst_oe", a_oe, 1'b0);

        // Busy behaviour on the instance with CLEAR_BUSY_CYC=2
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
        chk("bsy_clear_busy", b_busy, 1'b1);
        chk("bsy_clear_err", b_err, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h0C);
        chk("bsy_rej_err", b_err, 1'b1);
        chk("bsy_rej_disp", b_disp, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("bsy_bf_oe", b_oe, 1'b1);
        chk("bsy_bf_out", b_out, 8'h80);
        chk("bsy_err_pulse", b_err, 1'b0);
        chk("bsy_done", b_busy, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h0C);
        chk("bsy_acc_err", b_err, 1'b0);
        chk("bsy_acc_disp", b_disp, 1'b1);
        chk("bsy_oe_drop", b_oe, 1'b0);
        chk("bsy_a_untouched", a_disp, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
